// File: rtl/cascade_counter_pkg.sv
// Shared defaults, counter operation encoding and modulus wrap helper
// for the cascade_counter slice.
package cascade_counter_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MOD_VAL = 16;
    localparam int unsigned DEF_TC_VAL  = 12;
    localparam int unsigned DEF_PER_W   = 16;

    // Operation selected on an edge, already resolved by priority clr > load > enable
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT
    } cnt_op_e;

    // Successor of value in a modulus-wrapping up count (0..modulus-1)
    function automatic int unsigned next_mod(input int unsigned value, input int unsigned modulus);
        return (value >= modulus - 1) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/cascade_counter_if.sv
// Control/status bundle of cascade_counter. The master drives controls,
// the slave (the counter) drives counts and status.
interface cascade_counter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PER_W = 16
);
    logic             cnt_en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] pri_cnt;
    logic [WIDTH-1:0] sec_cnt;
    logic             tick;
    logic             sec_zero;
    logic [PER_W-1:0] period;
    logic             period_vld;

    modport master (
        output cnt_en, clr, load, load_val,
        input  pri_cnt, sec_cnt, tick, sec_zero, period, period_vld
    );

    modport slave (
        input  cnt_en, clr, load, load_val,
        output pri_cnt, sec_cnt, tick, sec_zero, period, period_vld
    );
endinterface

// File: rtl/cascade_counter_mod_counter.sv
// mod_counter: up counter wrapping at MOD_VAL with sync clear and load.
// Load values outside 0..MOD_VAL-1 load as 0.
module mod_counter
    import cascade_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MOD_VAL = DEF_MOD_VAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o
);

    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Resolve the edge operation and compute the next count
    always_comb begin
        op = OP_HOLD;
        if (clr_i)       op = OP_CLEAR;
        else if (load_i) op = OP_LOAD;
        else if (en_i)   op = OP_COUNT;

        cnt_d = cnt_q;
        case (op)
            OP_CLEAR: cnt_d = '0;
            OP_LOAD:  cnt_d = (32'(load_val_i) >= MOD_VAL) ? '0 : load_val_i;
            OP_COUNT: cnt_d = WIDTH'(next_mod(32'(cnt_q), MOD_VAL));
            default:  cnt_d = cnt_q;
        endcase
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cascade_counter.sv
// cascade_counter: primary modulus counter whose terminal count produces a
// registered tick that decrements a secondary down counter.
// Optional macro CASCADE_CNT_PERIOD_EN adds measurement of clk cycles between
// consecutive ticks; without it period/period_vld are tied to 0.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter int unsigned      MOD_VAL  = DEF_MOD_VAL,
    parameter int unsigned      TC_VAL   = DEF_TC_VAL,
    parameter logic [WIDTH-1:0] SEC_INIT = '1,
    parameter int unsigned      PER_W    = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    cascade_counter_if.slave bus
);

    logic [WIDTH-1:0] pri_cnt;
    logic [WIDTH-1:0] sec_q, sec_d;
    logic             tick_q, tick_d;
    logic [PER_W-1:0] period_q;
    logic             period_vld_q;

    mod_counter #(
        .WIDTH   (WIDTH),
        .MOD_VAL (MOD_VAL)
    ) u_pri (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (bus.cnt_en),
        .clr_i      (bus.clr),
        .load_i     (bus.load),
        .load_val_i (bus.load_val),
        .cnt_o      (pri_cnt)
    );

    // Arm tick when the primary advances past terminal count; clear decrements nothing
    always_comb begin
        tick_d = bus.cnt_en & (32'(pri_cnt) == TC_VAL) & ~bus.clr & ~bus.load;
        sec_d  = sec_q;
        if (bus.clr)     sec_d = SEC_INIT;
        else if (tick_q) sec_d = sec_q - 1'b1;
    end

    // Tick and secondary registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
            sec_q  <= SEC_INIT;
        end else begin
            tick_q <= tick_d;
            sec_q  <= sec_d;
        end
    end

`ifdef CASCADE_CNT_PERIOD_EN
    logic [PER_W-1:0] per_cnt_q, per_cnt_d, period_d;
    logic             armed_q, armed_d, period_vld_d;

    // First tick after reset/clear only arms; later ticks publish the cycle count
    always_comb begin
        per_cnt_d    = per_cnt_q;
        armed_d      = armed_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;
        if (bus.clr) begin
            per_cnt_d    = '0;
            armed_d      = 1'b0;
            period_vld_d = 1'b0;
        end else if (tick_q) begin
            per_cnt_d = PER_W'(1);
            armed_d   = 1'b1;
            if (armed_q) begin
                period_d     = per_cnt_q;
                period_vld_d = 1'b1;
            end
        end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    // Period measurement registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_q    <= '0;
            armed_q      <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            per_cnt_q    <= per_cnt_d;
            armed_q      <= armed_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end
`else
    assign period_q     = '0;
    assign period_vld_q = 1'b0;
`endif

    assign bus.pri_cnt    = pri_cnt;
    assign bus.sec_cnt    = sec_q;
    assign bus.tick       = tick_q;
    assign bus.sec_zero   = (sec_q == '0);
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter: directed stimulus, a behavioural reference model
// compared every cycle, and hand-computed literal expectations.
module tb_cascade_counter;

`ifdef CASCADE_CNT_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif
    localparam int MODV = 16;
    localparam int TC   = 12;
    localparam int PMAX = 65535;

    logic clk;
    logic rst;

    cascade_counter_if #(.WIDTH(4), .PER_W(16)) bus ();
    cascade_counter_if #(.WIDTH(5), .PER_W(16)) bus2 ();

    cascade_counter #(
        .WIDTH    (4),
        .MOD_VAL  (16),
        .TC_VAL   (12),
        .SEC_INIT (4'hF),
        .PER_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cascade_counter #(
        .WIDTH    (5),
        .MOD_VAL  (10),
        .TC_VAL   (3),
        .SEC_INIT (5'h1F),
        .PER_W    (16)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: counts as plain integers, period from edge timestamps
    int m_pri, m_sec, m_tick, m_edge, m_last, m_period, m_vld, m_armed;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pri <= 0; m_sec <= 15; m_tick <= 0; m_edge <= 0;
            m_last <= 0; m_period <= 0; m_vld <= 0; m_armed <= 0;
        end else begin
            m_edge <= m_edge + 1;
            m_tick <= (bus.cnt_en && m_pri == TC && !bus.clr && !bus.load) ? 1 : 0;
            m_sec  <= bus.clr ? 15 : (m_tick != 0 ? (m_sec + 15) % 16 : m_sec);
            if (bus.clr)           m_pri <= 0;
            else if (bus.load)     m_pri <= (int'(bus.load_val) >= MODV) ? 0 : int'(bus.load_val);
            else if (bus.cnt_en)   m_pri <= (m_pri + 1) % MODV;
            if (bus.clr) begin
                m_armed <= 0;
                m_vld   <= 0;
            end else if (m_tick != 0) begin
                if (m_armed != 0) begin
                    m_period <= (m_edge - m_last > PMAX) ? PMAX : m_edge - m_last;
                    m_vld    <= 1;
                end
                m_last  <= m_edge;
                m_armed <= 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("pri_cnt",    bus.pri_cnt,    m_pri);
            check("sec_cnt",    bus.sec_cnt,    m_sec);
            check("tick",       bus.tick,       m_tick);
            check("sec_zero",   bus.sec_zero,   (m_sec == 0) ? 1 : 0);
            check("period",     bus.period,     PER_EN ? m_period : 0);
            check("period_vld", bus.period_vld, PER_EN ? m_vld : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int zero_cnt;
    int t_tick;

    initial begin
        rst = 1'b1;
        bus.cnt_en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus2.cnt_en = 1'b0; bus2.clr = 1'b0; bus2.load = 1'b0; bus2.load_val = '0;
        step(2);
        check("reset_pri", bus.pri_cnt, 0);
        check("reset_sec", bus.sec_cnt, 15);
        check("reset_tick", bus.tick, 0);
        rst = 1'b0;
        bus.cnt_en = 1'b1;
        chk_on = 1'b1;

        // Primary sequence, single tick after edge 13, secondary 14 after edge 14
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("t1_pri", bus.pri_cnt, k % 16);
            check("t1_tick", bus.tick, (k == 13) ? 1 : 0);
            if (k == 14) check("t1_sec14", bus.sec_cnt, 14);
        end

        // Full secondary revolution
        zero_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            if (bus.sec_zero) zero_cnt++;
        end
        check("t2_zero_cycles", zero_cnt, 16);
        check("t2_sec_after_rev", bus.sec_cnt, 14);

        // Asynchronous reset between edges
        step(7);
        check("t3_pri7", bus.pri_cnt, 7);
        #2 rst = 1'b1;
        #1;
        check("t3_async_pri", bus.pri_cnt, 0);
        check("t3_async_sec", bus.sec_cnt, 15);
        check("t3_async_tick", bus.tick, 0);
        step(1);
        rst = 1'b0;
        step(1);
        check("t3_recount", bus.pri_cnt, 1);
        step(12);
        check("t3_tick_pri", bus.pri_cnt, 13);
        check("t3_tick", bus.tick, 1);

        // clr and load together during a tick: clr wins
        bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 4'd11;
        step(1);
        bus.clr = 1'b0; bus.load = 1'b0;
        check("t4_clr_pri", bus.pri_cnt, 0);
        check("t4_clr_sec", bus.sec_cnt, 15);
        check("t4_clr_tick", bus.tick, 0);
        if (PER_EN) check("t4_clr_vld", bus.period_vld, 0);

        // Load alone: tick two cycles later
        bus.load = 1'b1; bus.load_val = 4'd11;
        step(1);
        bus.load = 1'b0;
        check("t4_load_pri", bus.pri_cnt, 11);
        check("t4_load_tick0", bus.tick, 0);
        step(1);
        check("t4_load_tick1", bus.tick, 0);
        step(1);
        check("t4_load_tick2", bus.tick, 1);
        t_tick = cyc;

        // Stall at terminal count
        step(15);
        check("t5_pri12", bus.pri_cnt, 12);
        bus.cnt_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("t5_stall_tick", bus.tick, 0);
            check("t5_stall_pri", bus.pri_cnt, 12);
        end
        bus.cnt_en = 1'b1;
        step(1);
        check("t5_resume_tick", bus.tick, 1);
        check("t5_spacing", cyc - t_tick, 21);
        t_tick = cyc;
        step(1);
        if (PER_EN) begin
            check("t6_period21", bus.period, 21);
            check("t6_vld", bus.period_vld, 1);
        end
        step(15);
        check("t6_tick16", bus.tick, 1);
        check("t6_spacing16", cyc - t_tick, 16);
        step(1);
        if (PER_EN) check("t6_period16", bus.period, 16);
        else        check("t6_period_off", bus.period, 0);

        // Second instance, MOD_VAL=10, TC_VAL=3: out-of-range load and wrap
        bus2.load = 1'b1; bus2.load_val = 5'd20;
        step(1);
        check("m10_load20", bus2.pri_cnt, 0);
        bus2.load_val = 5'd7;
        step(1);
        check("m10_load7", bus2.pri_cnt, 7);
        bus2.load = 1'b0; bus2.cnt_en = 1'b1;
        step(3);
        check("m10_wrap", bus2.pri_cnt, 0);
        step(3);
        check("m10_pri3", bus2.pri_cnt, 3);
        check("m10_notick", bus2.tick, 0);
        step(1);
        check("m10_tick", bus2.tick, 1);
        check("m10_sec", bus2.sec_cnt, 31);
        step(1);
        check("m10_sec_dec", bus2.sec_cnt, 30);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
